multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/mc_aludec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   state_t       4-bit FSM state encoding (also exported on the debug port)
//   OP_*          instr[31:26] opcodes recognised by the decoder
//   FUNCT_*       instr[5:0] R-type function codes
//   ALU_*         alucontrol encodings
//   SRCB_*        alusrcb encodings
//   PC_*          pcsrc encodings
// Configuration: MULTICYCLE_JALJR_EN (see multicycle_ctrl) selects jal/jr support.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      BNEEX   = 4'd9,
      ADDIEX  = 4'd10,
      ORIEX   = 4'd11,
      IMMWB   = 4'd12,
      JEX     = 4'd13,
      JALEX   = 4'd14,
      JREX    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_REGA   = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational R-type funct -> alucontrol decoder.
// Ports:
//   funct       in  6  instr[5:0]
//   alucontrol  out 3  ALU operation; unknown functs fall back to add
module mc_aludec
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (funct)
         FUNCT_ADD: alucontrol = ALU_ADD;
         FUNCT_SUB: alucontrol = ALU_SUB;
         FUNCT_AND: alucontrol = ALU_AND;
         FUNCT_OR:  alucontrol = ALU_OR;
         FUNCT_SLT: alucontrol = ALU_SLT;
         default:   alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control FSM for a multicycle MIPS datapath.
// Ports:
//   clk, reset            clock (rising edge) and synchronous active-high reset
//   op, funct, zero       instr[31:26], instr[5:0], ALU zero flag
//   iord, irwrite, memwrite, memtoreg, regdst, regwrite, jal
//                         memory / register-file controls
//   alusrca, alusrcb, zeroext, alucontrol
//                         ALU operand and operation selects
//   pcsrc, pcen           next-PC select and PC enable
//   state                 current FSM state (debug)
// Configuration: define MULTICYCLE_JALJR_EN to enable the jal (JALEX) and
// jr (JREX) paths; otherwise both decode as NOPs and jal is tied low.
module multicycle_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       jal,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zeroext,
   output logic [2:0] alucontrol,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [3:0] state
);

   state_t     cur_state, next_state, dec_state;
   logic [2:0] alu_funct;
   logic       irwrite_raw, memwrite_raw, regwrite_raw;
   logic       pcwrite, branch, bne;
`ifdef MULTICYCLE_JALJR_EN
   logic       jal_raw;
`endif

   mc_aludec u_aludec (
      .funct      (funct),
      .alucontrol (alu_funct)
   );

   always_ff @(posedge clk) begin
      if (reset) cur_state <= FETCH;
      else       cur_state <= next_state;
   end

   always_comb begin
      next_state = FETCH;
      case (cur_state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE: begin
`ifdef MULTICYCLE_JALJR_EN
                  next_state = (funct == FUNCT_JR) ? JREX : RTYPEEX;
`else
                  next_state = (funct == FUNCT_JR) ? FETCH : RTYPEEX;
`endif
               end
               OP_BEQ:  next_state = BEQEX;
               OP_BNE:  next_state = BNEEX;
               OP_ADDI: next_state = ADDIEX;
               OP_ORI:  next_state = ORIEX;
               OP_J:    next_state = JEX;
`ifdef MULTICYCLE_JALJR_EN
               OP_JAL:  next_state = JALEX;
`endif
               default: next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   next_state = MEMWB;
         RTYPEEX: next_state = RTYPEWB;
         ADDIEX:  next_state = IMMWB;
         ORIEX:   next_state = IMMWB;
         default: next_state = FETCH;
      endcase
   end

   // While reset is held the outputs show the FETCH decode, with the
   // write strobes and PC enable masked below.
   assign dec_state = reset ? FETCH : cur_state;

   always_comb begin
      iord         = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      regwrite_raw = 1'b0;
`ifdef MULTICYCLE_JALJR_EN
      jal_raw      = 1'b0;
`endif
      alusrca      = 1'b0;
      alusrcb      = SRCB_REG;
      zeroext      = 1'b0;
      alucontrol   = ALU_ADD;
      pcsrc        = PC_ALU;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      bne          = 1'b0;
      case (dec_state)
         FETCH: begin
            irwrite_raw = 1'b1;
            alusrcb     = SRCB_FOUR;
            pcwrite     = 1'b1;
         end
         DECODE: alusrcb = SRCB_IMMSH;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD: iord = 1'b1;
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = alu_funct;
         end
         RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         BEQEX, BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = PC_ALUOUT;
            branch     = 1'b1;
            bne        = (dec_state == BNEEX);
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ORIEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            zeroext    = 1'b1;
            alucontrol = ALU_OR;
         end
         IMMWB: regwrite_raw = 1'b1;
         JEX: begin
            pcsrc   = PC_JUMP;
            pcwrite = 1'b1;
         end
`ifdef MULTICYCLE_JALJR_EN
         // PC already holds PC+4 from FETCH; it is the link value for r31.
         JALEX: begin
            pcsrc        = PC_JUMP;
            pcwrite      = 1'b1;
            jal_raw      = 1'b1;
            regwrite_raw = 1'b1;
         end
         JREX: begin
            pcsrc   = PC_REGA;
            pcwrite = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign irwrite  = irwrite_raw & ~reset;
   assign memwrite = memwrite_raw & ~reset;
   assign regwrite = regwrite_raw & ~reset;
   assign pcen     = ~reset & (pcwrite | (branch & (zero ^ bne)));
`ifdef MULTICYCLE_JALJR_EN
   assign jal      = jal_raw;
`else
   assign jal      = 1'b0;
`endif
   assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl. Each instruction
// is expanded into the list of cycles it should take, with the outputs every
// cycle must show; directed cases come first, then random op/funct/zero mixes
// with occasional mid-instruction resets.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, jal;
   logic       alusrca, zeroext, pcen;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

`ifdef MULTICYCLE_JALJR_EN
   localparam bit JALJR = 1'b1;
`else
   localparam bit JALJR = 1'b0;
`endif

   // pc_kind: 0 = PC held, 1 = PC written, 2 = written if zero, 3 = if !zero
   typedef struct packed {
      logic [3:0] st;
      logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, jal, alusrca;
      logic [1:0] alusrcb;
      logic       zeroext;
      logic [2:0] aluc;
      logic [1:0] pcsrc;
      logic [1:0] pc_kind;
   } step_t;

   step_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .iord       (iord),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .regwrite   (regwrite),
      .jal        (jal),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .zeroext    (zeroext),
      .alucontrol (alucontrol),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .state      (state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {11'd0, state, iord, irwrite, memwrite, memtoreg, regdst, regwrite, jal,
              alusrca, alusrcb, zeroext, alucontrol, pcsrc, pcen};
   endfunction

   function automatic logic [31:0] exp_vec(input step_t s, input logic z);
      logic pc;
      pc = (s.pc_kind == 2'd1) || (s.pc_kind == 2'd2 && z) || (s.pc_kind == 2'd3 && !z);
      return {11'd0, s.st, s.iord, s.irwrite, s.memwrite, s.memtoreg, s.regdst, s.regwrite,
              s.jal, s.alusrca, s.alusrcb, s.zeroext, s.aluc, s.pcsrc, pc};
   endfunction

   function automatic step_t mk(input logic [3:0] st);
      step_t s;
      s      = '0;
      s.st   = st;
      s.aluc = 3'b010;
      return s;
   endfunction

   function automatic step_t fetch_step(input logic [3:0] st, input bit in_reset);
      step_t s;
      s         = mk(st);
      s.irwrite = !in_reset;
      s.alusrcb = 2'b01;
      s.pc_kind = in_reset ? 2'd0 : 2'd1;
      return s;
   endfunction

   function automatic logic [2:0] ref_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic void build(input logic [5:0] o, input logic [5:0] f);
      step_t s, w;
      exp_q.delete();
      exp_q.push_back(fetch_step(4'd0, 1'b0));
      s = mk(4'd1);
      s.alusrcb = 2'b11;
      exp_q.push_back(s);
      case (o)
         6'b100011, 6'b101011: begin
            s = mk(4'd2); s.alusrca = 1; s.alusrcb = 2'b10;
            exp_q.push_back(s);
            if (o == 6'b100011) begin
               s = mk(4'd3); s.iord = 1;
               exp_q.push_back(s);
               s = mk(4'd4); s.memtoreg = 1; s.regwrite = 1;
               exp_q.push_back(s);
            end else begin
               s = mk(4'd5); s.iord = 1; s.memwrite = 1;
               exp_q.push_back(s);
            end
         end
         6'b000000: begin
            if (f == 6'b001000) begin
               if (JALJR) begin
                  s = mk(4'd15); s.pcsrc = 2'b11; s.pc_kind = 2'd1;
                  exp_q.push_back(s);
               end
            end else begin
               s = mk(4'd6); s.alusrca = 1; s.aluc = ref_alu(f);
               exp_q.push_back(s);
               w = mk(4'd7); w.regdst = 1; w.regwrite = 1;
               exp_q.push_back(w);
            end
         end
         6'b000100, 6'b000101: begin
            s = mk((o == 6'b000100) ? 4'd8 : 4'd9);
            s.alusrca = 1; s.aluc = 3'b110; s.pcsrc = 2'b01;
            s.pc_kind = (o == 6'b000100) ? 2'd2 : 2'd3;
            exp_q.push_back(s);
         end
         6'b001000, 6'b001101: begin
            s = mk((o == 6'b001000) ? 4'd10 : 4'd11);
            s.alusrca = 1; s.alusrcb = 2'b10;
            if (o == 6'b001101) begin
               s.zeroext = 1; s.aluc = 3'b001;
            end
            exp_q.push_back(s);
            w = mk(4'd12); w.regwrite = 1;
            exp_q.push_back(w);
         end
         6'b000010: begin
            s = mk(4'd13); s.pcsrc = 2'b10; s.pc_kind = 2'd1;
            exp_q.push_back(s);
         end
         6'b000011: begin
            if (JALJR) begin
               s = mk(4'd14); s.pcsrc = 2'b10; s.pc_kind = 2'd1; s.jal = 1; s.regwrite = 1;
               exp_q.push_back(s);
            end
         end
         default: ;
      endcase
   endfunction

   // Entered just after a negedge with the DUT in FETCH; leaves it the same way.
   // zmode < 0 randomises zero each cycle. abort_at >= 0 raises reset in that cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                            input int abort_at, input string name);
      build(o, f);
      op    = o;
      funct = f;
      for (int i = 0; i < exp_q.size(); i++) begin
         zero = (zmode < 0) ? 1'($urandom_range(1)) : zmode[0];
         if (i == abort_at) begin
            reset = 1'b1;
            #1;
            check_eq($sformatf("%s rst_in_step%0d", name, i), dut_vec(),
                     exp_vec(fetch_step(exp_q[i].st, 1'b1), zero));
            @(negedge clk);
            #1;
            check_eq($sformatf("%s rst_state", name), {28'd0, state}, 32'd0);
            check_eq($sformatf("%s rst_writes", name), {29'd0, memwrite, regwrite, pcen}, 32'd0);
            reset = 1'b0;
            return;
         end
         #1;
         check_eq($sformatf("%s op=%b f=%b step%0d", name, o, f, i), dut_vec(),
                  exp_vec(exp_q[i], zero));
         @(negedge clk);
      end
   endtask

   logic [5:0] ops_tbl[10];
   logic [5:0] fn_tbl[7];

   initial begin
      ops_tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                  6'b001000, 6'b001101, 6'b000010, 6'b000011, 6'b111111};
      fn_tbl  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                  6'b001000, 6'b000111};
      reset = 1'b1;
      op    = '0;
      funct = '0;
      zero  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_hold", dut_vec(), exp_vec(fetch_step(4'd0, 1'b1), zero));
      reset = 1'b0;

      run_instr(6'b100011, 6'b000000, -1, -1, "lw");
      run_instr(6'b000100, 6'b000000, 1, -1, "beq_z1");
      run_instr(6'b000100, 6'b000000, 0, -1, "beq_z0");
      run_instr(6'b000101, 6'b000000, 1, -1, "bne_z1");
      run_instr(6'b000101, 6'b000000, 0, -1, "bne_z0");
      run_instr(6'b000000, 6'b100010, -1, -1, "sub");
      run_instr(6'b000011, 6'b000000, -1, -1, "jal");
      run_instr(6'b000000, 6'b001000, -1, -1, "jr");
      run_instr(6'b111111, 6'b000000, -1, -1, "nop");
      run_instr(6'b101011, 6'b000000, -1, 3, "sw_rst_memwr");
      run_instr(6'b101011, 6'b000000, -1, -1, "sw");
      run_instr(6'b001000, 6'b000000, -1, -1, "addi");
      run_instr(6'b001101, 6'b000000, -1, -1, "ori");
      run_instr(6'b000010, 6'b000000, -1, -1, "j");
      run_instr(6'b000000, 6'b000111, -1, -1, "rtype_unknown");

      for (int n = 0; n < 300; n++) begin
         logic [5:0] o, f;
         int         ab;
         o  = ($urandom_range(4) == 0) ? 6'($urandom) : ops_tbl[$urandom_range(9)];
         f  = ($urandom_range(4) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(6)];
         build(o, f);
         ab = -1;
         if ($urandom_range(7) == 0 && exp_q.size() > 1)
            ab = $urandom_range(exp_q.size() - 1, 1);
         run_instr(o, f, -1, ab, "rand");
      end

      #1;
      check_eq("final_state", {28'd0, state}, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
